// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose: bridges the pipeline's memory operations onto a simple
// request/grant/rvalid data bus. One operation is in flight at a time. Loads
// return size-extended data, stores return 0. Misaligned or reserved-size
// requests are rejected in the cycle they arrive.
//
// Ports:
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   data_req_i, data_wr_i        request strobe, 1 = store / 0 = load
//   data_byte_i, zero_extnd_i    size (00 byte, 01 half, 10 word), load zero-extend
//   custom_instr_i               custom tag forwarded to the bus
//   addr_i, wr_data_i            byte address and store data
//   mem_req_o, mem_we_o,
//   mem_size_o, mem_addr_o,
//   mem_wdata_o, mem_custom_o    bus request channel
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                  bus grant and response channel
//   stall_o                      hold the pipeline
//   rd_valid_o, rd_data_o        one-cycle completion with result
//   misaligned_o                 one-cycle pulse for a rejected request
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN = 19
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            data_req_i,
  input  logic            data_wr_i,
  input  logic [1:0]      data_byte_i,
  input  logic            zero_extnd_i,
  input  logic [1:0]      custom_instr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [1:0]      mem_size_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [1:0]      mem_custom_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            misaligned_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, rd_data_q;
  logic [1:0]      size_q, custom_q;
  logic            we_q, zext_q;

  logic            misaligned;
  logic            accept;
  logic            capture;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wdata_masked;

  // Alignment check on the incoming request; the reserved size is treated
  // as misaligned so it never reaches the bus.
  always_comb begin
    misaligned = 1'b0;
    case (data_byte_i)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr_i[0];
      SIZE_WORD: misaligned = (addr_i[1:0] != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  end

  // reset_ni gates the IDLE-cycle combinational outputs so every output is
  // low while reset is held, even if the decoder keeps requesting.
  assign accept  = reset_ni && (state_q == IDLE) && data_req_i && !misaligned;
  assign capture = ((state_q == REQ) && mem_gnt_i && mem_rvalid_i) ||
                   ((state_q == WAIT) && mem_rvalid_i);

  // Next-state logic. rvalid without a grant in REQ is a stale response and
  // is ignored; so is any rvalid seen in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? DONE : WAIT;
      WAIT: if (mem_rvalid_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load result extension, using the size and extend mode latched with the
  // request rather than whatever the decoder is presenting now.
  always_comb begin
    load_ext = mem_rdata_i;
    case (size_q)
      SIZE_BYTE: load_ext = {{(XLEN-8){mem_rdata_i[7] & ~zext_q}}, mem_rdata_i[7:0]};
      SIZE_HALF: load_ext = {{(XLEN-16){mem_rdata_i[15] & ~zext_q}}, mem_rdata_i[15:0]};
      default:   load_ext = mem_rdata_i;
    endcase
  end

  // Store data is trimmed to the access size with the upper bits cleared.
  always_comb begin
    wdata_masked = wdata_q;
    case (size_q)
      SIZE_BYTE: wdata_masked = {{(XLEN-8){1'b0}}, wdata_q[7:0]};
      SIZE_HALF: wdata_masked = {{(XLEN-16){1'b0}}, wdata_q[15:0]};
      default:   wdata_masked = wdata_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Request fields are captured only when a request is accepted, so they
  // stay frozen through REQ and WAIT no matter what the inputs do.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      custom_q <= 2'b00;
    end else if (accept) begin
      addr_q   <= addr_i;
      wdata_q  <= wr_data_i;
      size_q   <= data_byte_i;
      we_q     <= data_wr_i;
      zext_q   <= zero_extnd_i;
      custom_q <= custom_instr_i;
    end
  end

  // Response capture; a store's acknowledgement yields a zero result.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    rd_data_q <= '0;
    else if (capture) rd_data_q <= we_q ? '0 : load_ext;
  end

  // Bus outputs carry the latched request only while REQ is active and are
  // zero otherwise, so a reset drops the request without waiting for grant.
  assign mem_req_o    = (state_q == REQ);
  assign mem_we_o     = mem_req_o & we_q;
  assign mem_size_o   = mem_req_o ? size_q : 2'b00;
  assign mem_addr_o   = mem_req_o ? addr_q : '0;
  assign mem_wdata_o  = (mem_req_o && we_q) ? wdata_masked : '0;
  assign mem_custom_o = mem_req_o ? custom_q : 2'b00;

  assign stall_o      = accept || (state_q == REQ) || (state_q == WAIT);
  assign rd_valid_o   = (state_q == DONE);
  assign rd_data_o    = rd_valid_o ? rd_data_q : '0;
  assign misaligned_o = reset_ni && (state_q == IDLE) && data_req_i && misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose: self-checking bench for load_store_unit. Directed scenarios from
// the block's worked examples, then randomized operations compared against
// an arithmetic reference model of load extension and store masking.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int XLEN = 19;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            data_req_i;
  logic            data_wr_i;
  logic [1:0]      data_byte_i;
  logic            zero_extnd_i;
  logic [1:0]      custom_instr_i;
  logic [XLEN-1:0] addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [1:0]      mem_size_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic [1:0]      mem_custom_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;
  logic            stall_o;
  logic            rd_valid_o;
  logic [XLEN-1:0] rd_data_o;
  logic            misaligned_o;

  int testsRun = 0;
  int testsFailed = 0;

  load_store_unit #(.XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .data_req_i     (data_req_i),
    .data_wr_i      (data_wr_i),
    .data_byte_i    (data_byte_i),
    .zero_extnd_i   (zero_extnd_i),
    .custom_instr_i (custom_instr_i),
    .addr_i         (addr_i),
    .wr_data_i      (wr_data_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_size_o     (mem_size_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_custom_o   (mem_custom_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .stall_o        (stall_o),
    .rd_valid_o     (rd_valid_o),
    .rd_data_o      (rd_data_o),
    .misaligned_o   (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: load result from plain arithmetic on the response value.
  function automatic logic [XLEN-1:0] modelLoad(input int size, input bit zext,
                                                input int unsigned rdata);
    int unsigned full;
    int unsigned v;
    full = 32'd1 << XLEN;
    v = rdata % full;
    if (size == 0) begin
      v = rdata % 256;
      if (!zext && v >= 128) v = v + full - 256;
    end else if (size == 1) begin
      v = rdata % 65536;
      if (!zext && v >= 32768) v = v + full - 65536;
    end
    return XLEN'(v);
  endfunction

  // Reference: store data keeps only the bytes of the access size.
  function automatic logic [XLEN-1:0] modelStore(input int size, input int unsigned wd);
    int unsigned v;
    if (size == 0)      v = wd % 256;
    else if (size == 1) v = wd % 65536;
    else                v = wd;
    return XLEN'(v);
  endfunction

  function automatic bit modelMisaligned(input int size, input int unsigned addr);
    return (size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0) || size == 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit req, input bit wr, input logic [1:0] size,
                               input bit zext, input logic [1:0] custom,
                               input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata);
    data_req_i     = req;
    data_wr_i      = wr;
    data_byte_i    = size;
    zero_extnd_i   = zext;
    custom_instr_i = custom;
    addr_i         = addr;
    wr_data_i      = wdata;
  endtask

  task automatic scrambleInputs();
    applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1), 2'($urandom_range(0, 3)), XLEN'($urandom), XLEN'($urandom));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, ".mem_req"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid_o), 32'd0);
    checkOutput({tag, ".misaligned"}, 32'(misaligned_o), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkIdleQuiet(tag);
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr_o), 32'd0);
    checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata_o), 32'd0);
    checkOutput({tag, ".mem_we"}, 32'(mem_we_o), 32'd0);
    checkOutput({tag, ".rd_data"}, 32'(rd_data_o), 32'd0);
  endtask

  task automatic checkBusFields(input string tag, input bit wr, input logic [1:0] size,
                                input logic [1:0] custom, input logic [XLEN-1:0] addr,
                                input logic [XLEN-1:0] expWdata);
    checkOutput({tag, ".mem_req"}, 32'(mem_req_o), 32'd1);
    checkOutput({tag, ".mem_we"}, 32'(mem_we_o), 32'(wr));
    checkOutput({tag, ".mem_size"}, 32'(mem_size_o), 32'(size));
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(addr));
    checkOutput({tag, ".mem_custom"}, 32'(mem_custom_o), 32'(custom));
    if (wr) checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata_o), 32'(expWdata));
    checkOutput({tag, ".stall"}, 32'(stall_o), 32'd1);
    checkOutput({tag, ".rd_valid"}, 32'(rd_valid_o), 32'd0);
  endtask

  // One complete aligned operation. Entered and left at posedge+1.
  task automatic runOp(input string tag, input bit wr, input logic [1:0] size, input bit zext,
                       input logic [1:0] custom, input logic [XLEN-1:0] addr,
                       input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] rdata,
                       input int gntWait, input int rvalidWait, input bit sameCycle);
    logic [XLEN-1:0] expWd;
    logic [XLEN-1:0] expRd;
    expWd = modelStore(int'(size), int'(wdata));
    expRd = wr ? '0 : modelLoad(int'(size), zext, int'(rdata));

    applyStimulus(1'b1, wr, size, zext, custom, addr, wdata);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    checkOutput({tag, ".c0.stall"}, 32'(stall_o), 32'd1);
    checkOutput({tag, ".c0.mem_req"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, ".c0.misaligned"}, 32'(misaligned_o), 32'd0);
    step();

    for (int i = 0; i < gntWait; i++) begin
      scrambleInputs();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = $urandom_range(0, 1);
      mem_rdata_i = XLEN'($urandom);
      @(negedge clk_i);
      checkBusFields({tag, ".req_wait"}, wr, size, custom, addr, expWd);
      step();
    end

    scrambleInputs();
    mem_gnt_i = 1'b1;
    mem_rvalid_i = sameCycle;
    mem_rdata_i = sameCycle ? rdata : XLEN'($urandom);
    @(negedge clk_i);
    checkBusFields({tag, ".req_gnt"}, wr, size, custom, addr, expWd);
    step();
    mem_gnt_i = 1'b0;

    if (!sameCycle) begin
      for (int i = 0; i <= rvalidWait; i++) begin
        scrambleInputs();
        mem_rvalid_i = (i == rvalidWait);
        mem_rdata_i = (i == rvalidWait) ? rdata : XLEN'($urandom);
        @(negedge clk_i);
        checkOutput({tag, ".wait.mem_req"}, 32'(mem_req_o), 32'd0);
        checkOutput({tag, ".wait.stall"}, 32'(stall_o), 32'd1);
        checkOutput({tag, ".wait.rd_valid"}, 32'(rd_valid_o), 32'd0);
        step();
      end
    end

    // Completion cycle: a held request and a stale response are both ignored.
    scrambleInputs();
    data_req_i = 1'b1;
    mem_rvalid_i = $urandom_range(0, 1);
    mem_rdata_i = XLEN'($urandom);
    @(negedge clk_i);
    checkOutput({tag, ".done.rd_valid"}, 32'(rd_valid_o), 32'd1);
    checkOutput({tag, ".done.rd_data"}, 32'(rd_data_o), 32'(expRd));
    checkOutput({tag, ".done.stall"}, 32'(stall_o), 32'd0);
    checkOutput({tag, ".done.mem_req"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, ".done.misaligned"}, 32'(misaligned_o), 32'd0);
    step();

    data_req_i = 1'b0;
    mem_rvalid_i = $urandom_range(0, 1);
    @(negedge clk_i);
    checkIdleQuiet({tag, ".after"});
    step();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic runMisaligned(input string tag, input logic [1:0] size,
                               input logic [XLEN-1:0] addr);
    applyStimulus(1'b1, $urandom_range(0, 1), size, 1'b0, 2'd0, addr, XLEN'($urandom));
    @(negedge clk_i);
    checkOutput({tag, ".misaligned"}, 32'(misaligned_o), 32'd1);
    checkOutput({tag, ".mem_req"}, 32'(mem_req_o), 32'd0);
    checkOutput({tag, ".stall"}, 32'(stall_o), 32'd0);
    step();
    data_req_i = 1'b0;
    @(negedge clk_i);
    checkIdleQuiet({tag, ".next"});
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]      sz;
    logic [XLEN-1:0] ad;
    int              gw, rw;

    // Reset held with a live aligned request: everything must stay low.
    reset_ni = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'd1, 19'h00004, 19'h12345);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    #12;
    checkAllZero("reset");
    data_req_i = 1'b0;
    step();
    reset_ni = 1'b1;
    step();

    // Worked examples.
    runOp("LB", 1'b0, 2'b00, 1'b0, 2'd0, 19'h00004, 19'h0, 19'h000F0, 0, 0, 1'b0);
    runOp("LBU", 1'b0, 2'b00, 1'b1, 2'd0, 19'h00004, 19'h0, 19'h000F0, 0, 0, 1'b0);
    runOp("LH", 1'b0, 2'b01, 1'b0, 2'd2, 19'h00002, 19'h0, 19'h08001, 0, 0, 1'b0);
    runOp("SB", 1'b1, 2'b00, 1'b0, 2'd3, 19'h00010, 19'h12345, 19'h0, 3, 0, 1'b0);
    runOp("LW_same", 1'b0, 2'b10, 1'b0, 2'd1, 19'h00008, 19'h0, 19'h00ABC, 0, 0, 1'b1);
    runMisaligned("SW_addr2", 2'b10, 19'h00002);
    runMisaligned("size11", 2'b11, 19'h00000);
    runMisaligned("LH_odd", 2'b01, 19'h00001);

    // Reset while in WAIT, then a late response must not complete anything.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 2'd0, 19'h00020, 19'h0);
    step();
    data_req_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    #2;
    reset_ni = 1'b0;
    #1;
    checkAllZero("rst_wait");
    step();
    reset_ni = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 19'h55555;
    @(negedge clk_i);
    checkIdleQuiet("rst_wait.rvalid");
    step();
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    checkIdleQuiet("rst_wait.idle");
    step();

    // Reset while in REQ drops the request without a grant.
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 2'd2, 19'h00040, 19'h0BEEF);
    step();
    data_req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_req.before", 32'(mem_req_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    checkAllZero("rst_req");
    step();
    reset_ni = 1'b1;
    step();

    // Fresh request after reset.
    runOp("post_rst", 1'b0, 2'b01, 1'b1, 2'd0, 19'h00046, 19'h0, 19'h0F00D, 1, 1, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 2));
      ad = XLEN'($urandom);
      if (sz == 2'b01) ad[0] = 1'b0;
      if (sz == 2'b10) ad[1:0] = 2'b00;
      gw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      runOp("rand", $urandom_range(0, 1), sz, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
            ad, XLEN'($urandom), XLEN'($urandom), gw, rw, $urandom_range(0, 1));
    end

    for (int n = 0; n < 10; n++) begin
      sz = 2'($urandom_range(1, 3));
      ad = XLEN'($urandom);
      if (sz == 2'b01) ad[0] = 1'b1;
      if (sz == 2'b10 && ad[1:0] == 2'b00) ad[0] = 1'b1;
      if (modelMisaligned(int'(sz), int'(ad))) runMisaligned("rand_mis", sz, ad);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
